// File: rtl/instr_stream_encoder_if.sv
// +----------------------------------------------------------------------------+
// | instr_stream_encoder_if : request and instruction-memory write channels     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface instr_stream_encoder_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op;
  logic [4:0]        rd;
  logic [4:0]        rn;
  logic [4:0]        rm;
  logic [18:0]       imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;

  // master: the program source / memory model; slave: the encoder
  modport master (
    output in_valid, op, rd, rn, rm, imm, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, op, rd, rn, rm, imm, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/instr_stream_encoder.sv
// +----------------------------------------------------------------------------+
// | instr_stream_encoder : encodes LEGv8 requests and writes them to imem       |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module instr_stream_encoder #(
  parameter int ADDR_W = 6
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              clear_i,
  instr_stream_encoder_if.slave  bus,
  output logic [ADDR_W:0]        count_o,
  output logic                   full_o,
  output logic                   err_o
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_ORR  = 3'd3;
  localparam logic [2:0] OP_LDUR = 3'd4;
  localparam logic [2:0] OP_STUR = 3'd5;
  localparam logic [2:0] OP_CBZ  = 3'd6;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            state_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [ADDR_W:0]   count_q;
  logic              err_q;

  logic [31:0]       word_d;
  logic              legal_d;
  logic              d_imm_ok;
  logic [ADDR_W:0]   count_d;

  // D-type offset must fit in 9 signed bits: the upper bits are pure sign
  assign d_imm_ok = (&bus.imm[18:8]) | ~(|bus.imm[18:8]);
  assign count_d  = count_q + 1'b1;

  always_comb begin
    word_d  = '0;
    legal_d = 1'b1;
    case (bus.op)
      OP_ADD:  word_d = {OPC_ADD, bus.rm, 6'b0, bus.rn, bus.rd};
      OP_SUB:  word_d = {OPC_SUB, bus.rm, 6'b0, bus.rn, bus.rd};
      OP_AND:  word_d = {OPC_AND, bus.rm, 6'b0, bus.rn, bus.rd};
      OP_ORR:  word_d = {OPC_ORR, bus.rm, 6'b0, bus.rn, bus.rd};
      OP_LDUR: begin
        word_d  = {OPC_LDUR, bus.imm[8:0], 2'b00, bus.rn, bus.rd};
        legal_d = d_imm_ok;
      end
      OP_STUR: begin
        word_d  = {OPC_STUR, bus.imm[8:0], 2'b00, bus.rn, bus.rd};
        legal_d = d_imm_ok;
      end
      OP_CBZ:  word_d = {OPC_CBZ, bus.imm, bus.rd};
      default: legal_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else if (clear_i) begin
      state_q    <= S_IDLE;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            if (legal_d) begin
              mem_wdata_q <= word_d;
              mem_we_q    <= 1'b1;
              state_q     <= S_WRITE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (bus.mem_ready) begin
            mem_we_q <= 1'b0;
            count_q  <= count_d;
            // Hold the last address when full so no out-of-range address appears
            if (count_d == DEPTH) begin
              state_q <= S_FULL;
            end else begin
              mem_addr_q <= mem_addr_q + 1'b1;
              state_q    <= S_IDLE;
            end
          end
        end
        S_FULL: begin
          mem_we_q <= 1'b0;
        end
        default: begin
          state_q  <= S_IDLE;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign count_o       = count_q;
  assign full_o        = (count_q == DEPTH);
  assign err_o         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_stream_encoder.sv
// +----------------------------------------------------------------------------+
// | tb_instr_stream_encoder : directed bench for 64-word and 4-word encoders    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_instr_stream_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        sel_b;
  logic        in_valid;
  logic [2:0]  op;
  logic [4:0]  rd, rn, rm;
  logic [18:0] imm;
  logic        mem_ready;

  int n_checks = 0;
  int n_fails  = 0;
  int wr_cnt   = 0;
  int exp_cnt  = 0;

  instr_stream_encoder_if #(.ADDR_W(6)) a_if ();
  instr_stream_encoder_if #(.ADDR_W(2)) b_if ();

  logic [6:0] cnt_a;
  logic [2:0] cnt_b;
  logic       full_a, full_b, err_a, err_b;

  instr_stream_encoder #(.ADDR_W(6)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .clear_i(clear), .bus(a_if.slave),
    .count_o(cnt_a), .full_o(full_a), .err_o(err_a)
  );

  instr_stream_encoder #(.ADDR_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clear_i(clear), .bus(b_if.slave),
    .count_o(cnt_b), .full_o(full_b), .err_o(err_b)
  );

  assign a_if.in_valid  = in_valid & ~sel_b;
  assign b_if.in_valid  = in_valid & sel_b;
  assign a_if.op        = op;
  assign b_if.op        = op;
  assign a_if.rd        = rd;
  assign b_if.rd        = rd;
  assign a_if.rn        = rn;
  assign b_if.rn        = rn;
  assign a_if.rm        = rm;
  assign b_if.rm        = rm;
  assign a_if.imm       = imm;
  assign b_if.imm       = imm;
  assign a_if.mem_ready = mem_ready;
  assign b_if.mem_ready = mem_ready;

  // Outputs of whichever encoder is under test
  logic        o_we, o_rdy, o_full, o_err;
  logic [5:0]  o_addr;
  logic [31:0] o_data;
  logic [6:0]  o_cnt;
  assign o_we   = sel_b ? b_if.mem_we   : a_if.mem_we;
  assign o_rdy  = sel_b ? b_if.in_ready : a_if.in_ready;
  assign o_addr = sel_b ? {4'b0, b_if.mem_addr} : a_if.mem_addr;
  assign o_data = sel_b ? b_if.mem_wdata : a_if.mem_wdata;
  assign o_cnt  = sel_b ? {4'b0, cnt_b} : cnt_a;
  assign o_full = sel_b ? full_b : full_a;
  assign o_err  = sel_b ? err_b  : err_a;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_we && mem_ready) wr_cnt <= wr_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [4:0] d, input logic [4:0] n,
                       input logic [4:0] m, input logic [18:0] i);
    @(negedge clk);
    in_valid = 1'b1; op = o; rd = d; rn = n; rm = m; imm = i;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic put(input string tag, input logic [2:0] o, input logic [4:0] d,
                     input logic [4:0] n, input logic [4:0] m, input logic [18:0] i,
                     input logic [5:0] ea, input logic [31:0] ew);
    int w0;
    w0 = wr_cnt;
    issue(o, d, n, m, i);
    check_eq({tag, ".we"},    64'(o_we),   64'd1);
    check_eq({tag, ".addr"},  64'(o_addr), 64'(ea));
    check_eq({tag, ".wdata"}, 64'(o_data), 64'(ew));
    check_eq({tag, ".rdy"},   64'(o_rdy),  64'd0);
    @(posedge clk);
    #1;
    exp_cnt++;
    check_eq({tag, ".we_off"}, 64'(o_we),   64'd0);
    check_eq({tag, ".count"},  64'(o_cnt),  64'(exp_cnt));
    check_eq({tag, ".writes"}, 64'(wr_cnt), 64'(w0 + 1));
  endtask

  task automatic reject(input string tag, input logic [2:0] o, input logic [18:0] i);
    int w0;
    w0 = wr_cnt;
    issue(o, 5'd1, 5'd2, 5'd3, i);
    check_eq({tag, ".we"},  64'(o_we),  64'd0);
    check_eq({tag, ".rdy"}, 64'(o_rdy), 64'd1);
    check_eq({tag, ".err"}, 64'(o_err), 64'd1);
    @(posedge clk);
    #1;
    check_eq({tag, ".count"},  64'(o_cnt),  64'(exp_cnt));
    check_eq({tag, ".writes"}, 64'(wr_cnt), 64'(w0));
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear   = 1'b0;
    exp_cnt = 0;
  endtask

  initial begin
    int w0;
    rst_n = 1'b0; clear = 1'b0; sel_b = 1'b0; in_valid = 1'b0;
    op = '0; rd = '0; rn = '0; rm = '0; imm = '0; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst.we",    64'(o_we),   64'd0);
    check_eq("rst.addr",  64'(o_addr), 64'd0);
    check_eq("rst.wdata", 64'(o_data), 64'd0);
    check_eq("rst.count", 64'(o_cnt),  64'd0);
    check_eq("rst.full",  64'(o_full), 64'd0);
    check_eq("rst.err",   64'(o_err),  64'd0);
    check_eq("rst.rdy",   64'(o_rdy),  64'd1);

    put("add", 3'd0, 5'd1, 5'd2, 5'd3, 19'h0, 6'd0, 32'h8B030041);
    do_clear();
    check_eq("clr.count", 64'(o_cnt),  64'd0);
    check_eq("clr.addr",  64'(o_addr), 64'd0);

    put("ldur",   3'd4, 5'd9,  5'd10, 5'd0,  19'h00008, 6'd0, 32'hF8408149);
    put("stur",   3'd5, 5'd9,  5'd10, 5'd0,  19'h7FFF8, 6'd1, 32'hF81F8149);
    put("cbz",    3'd6, 5'd5,  5'd0,  5'd0,  19'h7FFFE, 6'd2, 32'hB4FFFFC5);
    put("sub0",   3'd1, 5'd0,  5'd0,  5'd0,  19'h0,     6'd3, 32'hCB000000);
    put("and31",  3'd2, 5'd31, 5'd31, 5'd31, 19'h0,     6'd4, 32'h8A1F03FF);
    put("orr",    3'd3, 5'd1,  5'd2,  5'd3,  19'h0,     6'd5, 32'hAA030041);
    put("ldurmn", 3'd4, 5'd0,  5'd0,  5'd0,  19'h7FF00, 6'd6, 32'hF8500000);
    put("sturmx", 3'd5, 5'd0,  5'd0,  5'd0,  19'h000FF, 6'd7, 32'hF80FF000);

    reject("ldur256", 3'd4, 19'h00100);
    reject("op7",     3'd7, 19'h0);
    reject("stur257", 3'd5, 19'h7FEFF);
    put("after_rej", 3'd0, 5'd1, 5'd2, 5'd3, 19'h0, 6'd8, 32'h8B030041);
    check_eq("err.sticky", 64'(o_err), 64'd1);

    // Memory stall: word must stay put until mem_ready returns
    mem_ready = 1'b0;
    w0 = wr_cnt;
    issue(3'd3, 5'd1, 5'd2, 5'd3, 19'h0);
    for (int k = 0; k < 5; k++) begin
      check_eq("stall.we",    64'(o_we),   64'd1);
      check_eq("stall.addr",  64'(o_addr), 64'd9);
      check_eq("stall.wdata", 64'(o_data), 64'hAA030041);
      check_eq("stall.rdy",   64'(o_rdy),  64'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_cnt++;
    check_eq("stall.we_off", 64'(o_we),   64'd0);
    check_eq("stall.count",  64'(o_cnt),  64'd10);
    check_eq("stall.writes", 64'(wr_cnt), 64'(w0 + 1));

    // Clear during a stall discards the pending word
    mem_ready = 1'b0;
    w0 = wr_cnt;
    issue(3'd0, 5'd4, 5'd5, 5'd6, 19'h0);
    check_eq("sclr.we_pre", 64'(o_we), 64'd1);
    repeat (2) @(posedge clk);
    do_clear();
    check_eq("sclr.we",    64'(o_we),   64'd0);
    check_eq("sclr.addr",  64'(o_addr), 64'd0);
    check_eq("sclr.count", 64'(o_cnt),  64'd0);
    check_eq("sclr.err",   64'(o_err),  64'd0);
    check_eq("sclr.rdy",   64'(o_rdy),  64'd1);
    @(negedge clk);
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("sclr.writes", 64'(wr_cnt), 64'(w0));

    // Reset in the middle of a write drops mem_we immediately
    mem_ready = 1'b0;
    issue(3'd1, 5'd7, 5'd8, 5'd9, 19'h0);
    check_eq("arst.we_pre", 64'(o_we), 64'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst.we",  64'(o_we),  64'd0);
    check_eq("arst.rdy", 64'(o_rdy), 64'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    exp_cnt   = 0;
    #1;
    check_eq("arst.count", 64'(o_cnt), 64'd0);

    // Four-word instance: fill, refuse, clear, reuse address 0
    sel_b = 1'b1;
    do_clear();
    put("b0", 3'd0, 5'd1, 5'd2, 5'd3, 19'h0,     6'd0, 32'h8B030041);
    put("b1", 3'd1, 5'd0, 5'd0, 5'd0, 19'h0,     6'd1, 32'hCB000000);
    put("b2", 3'd6, 5'd5, 5'd0, 5'd0, 19'h7FFFE, 6'd2, 32'hB4FFFFC5);
    put("b3", 3'd4, 5'd9, 5'd10, 5'd0, 19'h8,    6'd3, 32'hF8408149);
    check_eq("bfull.full", 64'(o_full), 64'd1);
    check_eq("bfull.rdy",  64'(o_rdy),  64'd0);
    w0 = wr_cnt;
    issue(3'd0, 5'd1, 5'd1, 5'd1, 19'h0);
    check_eq("bfull.we", 64'(o_we), 64'd0);
    @(posedge clk);
    #1;
    check_eq("bfull.count",  64'(o_cnt),  64'd4);
    check_eq("bfull.hold",   64'(o_full), 64'd1);
    check_eq("bfull.writes", 64'(wr_cnt), 64'(w0));
    do_clear();
    check_eq("bclr.full",  64'(o_full), 64'd0);
    check_eq("bclr.count", 64'(o_cnt),  64'd0);
    check_eq("bclr.rdy",   64'(o_rdy),  64'd1);
    put("b_again", 3'd3, 5'd1, 5'd2, 5'd3, 19'h0, 6'd0, 32'hAA030041);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
